// File: rtl/t2c_move_tracker.sv
// Explorer position/heading tracker for a ROWS x COLS grid with exit and bounds detection.
// Optional visited-cell map enabled by defining MOVE_TRACKER_VISIT_MAP_EN.
module t2c_move_tracker #(
  parameter int ROWS      = 9,
  parameter int COLS      = 9,
  parameter int START_ROW = 4,
  parameter int START_COL = 0,
  parameter int EXIT_ROW  = 4,
  parameter int EXIT_COL  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] move,
  output logic [3:0] pos_row,
  output logic [3:0] pos_col,
  output logic [1:0] heading,
  output logic [7:0] step_cnt,
  output logic [3:0] deadend_cnt,
  output logic       exit_reached,
  output logic       oob_err,
`ifdef MOVE_TRACKER_VISIT_MAP_EN
  output logic       revisit,
  output logic [6:0] unique_cells,
`endif
  output logic       illegal_cmd
);

  typedef enum logic [1:0] {IDLE, TRACK, DONE, ERROR} state_t;

  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);
  localparam logic [3:0] EXIT_R  = 4'(EXIT_ROW);
  localparam logic [3:0] EXIT_C  = 4'(EXIT_COL);

  state_t     state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic [1:0] heading_q, heading_d;
  logic [7:0] step_q, step_d;
  logic [3:0] dead_q, dead_d;
  logic       exit_q, exit_d, oob_q, oob_d, illegal_q, illegal_d;

  logic       apply;
  logic [1:0] hdg_new;
  logic       at_edge;
  logic [3:0] row_adv, col_adv;

`ifdef MOVE_TRACKER_VISIT_MAP_EN
  localparam int CELLS     = ROWS * COLS;
  localparam int IW        = $clog2(CELLS);
  localparam int START_IDX = START_ROW * COLS + START_COL;

  logic [CELLS-1:0] visited_q, visited_d;
  logic [6:0]       uniq_q, uniq_d;
  logic             revisit_q, revisit_d;
  logic [IW-1:0]    adv_idx;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    heading_d = heading_q;
    step_d    = step_q;
    dead_d    = dead_q;
    exit_d    = exit_q;
    oob_d     = oob_q;
    illegal_d = (move > 3'd4);

    apply = ((state_q == IDLE) || (state_q == TRACK)) && (move >= 3'd1) && (move <= 3'd4);

    case (move)
      3'd2:    hdg_new = heading_q - 2'd1;
      3'd3:    hdg_new = heading_q + 2'd1;
      3'd4:    hdg_new = heading_q + 2'd2;
      default: hdg_new = heading_q;
    endcase

    // Bounds are judged on the current cell so a wrapped coordinate is never formed.
    row_adv = row_q;
    col_adv = col_q;
    case (hdg_new)
      2'd0: begin at_edge = (col_q == COL_MAX); col_adv = col_q + 4'd1; end
      2'd1: begin at_edge = (row_q == ROW_MAX); row_adv = row_q + 4'd1; end
      2'd2: begin at_edge = (col_q == 4'd0);    col_adv = col_q - 4'd1; end
      default: begin at_edge = (row_q == 4'd0); row_adv = row_q - 4'd1; end
    endcase

`ifdef MOVE_TRACKER_VISIT_MAP_EN
    visited_d = visited_q;
    uniq_d    = uniq_q;
    revisit_d = 1'b0;
    adv_idx   = IW'(int'(row_adv) * COLS + int'(col_adv));
`endif

    if (apply) begin
      heading_d = hdg_new;
      if (move == 3'd4 && dead_q != 4'd15) dead_d = dead_q + 4'd1;
      if (at_edge) begin
        oob_d   = 1'b1;
        state_d = ERROR;
      end else begin
        row_d = row_adv;
        col_d = col_adv;
        if (step_q != 8'd255) step_d = step_q + 8'd1;
        if (row_adv == EXIT_R && col_adv == EXIT_C) begin
          exit_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = TRACK;
        end
`ifdef MOVE_TRACKER_VISIT_MAP_EN
        if (visited_q[adv_idx]) begin
          revisit_d = 1'b1;
        end else begin
          visited_d[adv_idx] = 1'b1;
          if (uniq_q != 7'd127) uniq_d = uniq_q + 7'd1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= 4'(START_ROW);
      col_q     <= 4'(START_COL);
      heading_q <= 2'd0;
      step_q    <= 8'd0;
      dead_q    <= 4'd0;
      exit_q    <= 1'b0;
      oob_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      heading_q <= heading_d;
      step_q    <= step_d;
      dead_q    <= dead_d;
      exit_q    <= exit_d;
      oob_q     <= oob_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MOVE_TRACKER_VISIT_MAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visited_q            <= '0;
      visited_q[START_IDX] <= 1'b1;
      uniq_q               <= 7'd1;
      revisit_q            <= 1'b0;
    end else begin
      visited_q <= visited_d;
      uniq_q    <= uniq_d;
      revisit_q <= revisit_d;
    end
  end

  assign revisit      = revisit_q;
  assign unique_cells = uniq_q;
`endif

  assign pos_row      = row_q;
  assign pos_col      = col_q;
  assign heading      = heading_q;
  assign step_cnt     = step_q;
  assign deadend_cnt  = dead_q;
  assign exit_reached = exit_q;
  assign oob_err      = oob_q;
  assign illegal_cmd  = illegal_q;

endmodule

// File: tb/tb_t2c_move_tracker.sv
// Bench for t2c_move_tracker: directed scenarios plus random walks against a grid-level model.
module tb_t2c_move_tracker;
  localparam int ROWS = 9, COLS = 9;
  localparam int START_ROW = 4, START_COL = 0, EXIT_ROW = 4, EXIT_COL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] move;
  logic [3:0] pos_row, pos_col, deadend_cnt;
  logic [1:0] heading;
  logic [7:0] step_cnt;
  logic       exit_reached, oob_err, illegal_cmd;
`ifdef MOVE_TRACKER_VISIT_MAP_EN
  logic       revisit;
  logic [6:0] unique_cells;
`endif

  always #5 clk = ~clk;

  t2c_move_tracker dut (
    .clk(clk), .rst_n(rst_n), .move(move),
    .pos_row(pos_row), .pos_col(pos_col), .heading(heading),
    .step_cnt(step_cnt), .deadend_cnt(deadend_cnt),
    .exit_reached(exit_reached), .oob_err(oob_err),
`ifdef MOVE_TRACKER_VISIT_MAP_EN
    .revisit(revisit), .unique_cells(unique_cells),
`endif
    .illegal_cmd(illegal_cmd)
  );

  int compared = 0, mismatched = 0;
  string cur_tag = "init";

  // Reference model: grid coordinates as plain integers; mode 0 idle, 1 tracking, 2 exited, 3 out of bounds.
  int m_r, m_c, m_h, m_steps, m_dead, m_mode, m_exit, m_oob, m_ill, m_rev, m_uniq;
  bit vis [ROWS][COLS];
  int dr [4] = '{0, 1, 0, -1};
  int dc [4] = '{1, 0, -1, 0};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s [%s]: got %0d expected %0d", cur_tag, tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("pos_row", 32'(pos_row), 32'(m_r));
    check_val("pos_col", 32'(pos_col), 32'(m_c));
    check_val("heading", 32'(heading), 32'(m_h));
    check_val("step_cnt", 32'(step_cnt), 32'(m_steps));
    check_val("deadend_cnt", 32'(deadend_cnt), 32'(m_dead));
    check_val("exit_reached", 32'(exit_reached), 32'(m_exit));
    check_val("oob_err", 32'(oob_err), 32'(m_oob));
    check_val("illegal_cmd", 32'(illegal_cmd), 32'(m_ill));
`ifdef MOVE_TRACKER_VISIT_MAP_EN
    check_val("revisit", 32'(revisit), 32'(m_rev));
    check_val("unique_cells", 32'(unique_cells), 32'(m_uniq));
`endif
  endtask

  task automatic model_reset();
    m_r = START_ROW; m_c = START_COL; m_h = 0; m_steps = 0; m_dead = 0;
    m_mode = 0; m_exit = 0; m_oob = 0; m_ill = 0; m_rev = 0; m_uniq = 1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        vis[r][c] = 1'b0;
    vis[START_ROW][START_COL] = 1'b1;
  endtask

  task automatic model_step(input int m);
    int nr, nc;
    m_ill = (m > 4) ? 1 : 0;
    m_rev = 0;
    if (m == 0 || m > 4 || m_mode >= 2) return;
    if (m == 2) m_h = (m_h + 3) % 4;
    if (m == 3) m_h = (m_h + 1) % 4;
    if (m == 4) begin
      m_h = (m_h + 2) % 4;
      if (m_dead < 15) m_dead++;
    end
    nr = m_r + dr[m_h];
    nc = m_c + dc[m_h];
    if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) begin
      m_oob = 1;
      m_mode = 3;
    end else begin
      m_r = nr; m_c = nc;
      if (m_steps < 255) m_steps++;
      if (vis[nr][nc]) m_rev = 1;
      else begin
        vis[nr][nc] = 1'b1;
        m_uniq++;
      end
      if (nr == EXIT_ROW && nc == EXIT_COL) begin
        m_exit = 1;
        m_mode = 2;
      end else m_mode = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    move  = 3'd0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int m);
    @(negedge clk);
    move = 3'(m);
    @(posedge clk);
    model_step(m);
    #1;
    check_all();
  endtask

  // Reset asserted between edges must clear outputs with no clock edge involved.
  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rand_move();
    int k;
    k = int'($urandom_range(0, 9));
    if (k <= 3) return 1;
    if (k == 4) return 0;
    if (k == 5) return 2;
    if (k == 6) return 3;
    if (k == 7) return 4;
    return int'($urandom_range(5, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    move  = 3'd0;
    model_reset();

    cur_tag = "reset";
    do_reset();
    $display("txn reset: pos=(%0d,%0d) heading=%0d", pos_row, pos_col, heading);

    cur_tag = "fwd3";
    for (int i = 0; i < 3; i++) step(1);
    check_val("fwd3_col_exact", 32'(pos_col), 32'd3);
    $display("txn fwd3: pos=(%0d,%0d) steps=%0d", pos_row, pos_col, step_cnt);

    cur_tag = "right_left";
    do_reset();
    step(3);
    step(2);
    $display("txn right_left: pos=(%0d,%0d) heading=%0d", pos_row, pos_col, heading);

    cur_tag = "exit";
    do_reset();
    for (int i = 0; i < 10; i++) step(1);
    check_val("exit_steps_exact", 32'(step_cnt), 32'd8);
    cur_tag = "exit_areset";
    async_reset_check();
    $display("txn exit: frozen then async reset");

    cur_tag = "uturn_oob";
    do_reset();
    step(4);
    step(1);
    step(3);
    step(4);
    check_val("oob_dead_exact", 32'(deadend_cnt), 32'd1);
    $display("txn uturn_oob: pos=(%0d,%0d) oob=%0d", pos_row, pos_col, oob_err);

    cur_tag = "illegal";
    do_reset();
    step(1);
    step(7);
    step(0);
    step(5);
    step(6);
    step(1);
    cur_tag = "illegal_areset";
    async_reset_check();
    $display("txn illegal: codes 7,5,6 applied");

    cur_tag = "revisit";
    do_reset();
    step(1);
    step(4);
    $display("txn revisit: pos=(%0d,%0d)", pos_row, pos_col);

    cur_tag = "saturate";
    do_reset();
    step(1);
    for (int i = 0; i < 300; i++) step(4);
    check_val("sat_steps_exact", 32'(step_cnt), 32'd255);
    check_val("sat_dead_exact", 32'(deadend_cnt), 32'd15);
    $display("txn saturate: steps=%0d deadends=%0d", step_cnt, deadend_cnt);

    for (int ep = 0; ep < 40; ep++) begin
      cur_tag = $sformatf("rand%0d", ep);
      do_reset();
      for (int i = 0; i < 40; i++) step(rand_move());
      if (ep % 8 == 7) async_reset_check();
      $display("txn %s: pos=(%0d,%0d) steps=%0d exit=%0d oob=%0d", cur_tag,
               pos_row, pos_col, step_cnt, exit_reached, oob_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/t2c_move_tracker.md
T2C_MOVE_TRACKER -- requirements
Module: t2c_move_tracker

Interface
REQ-001 The block SHALL have parameters ROWS, 9, grid rows; COLS, 9, grid columns.
REQ-002 The block SHALL have parameters START_ROW, 4, START_COL, 0, entry cell; EXIT_ROW, 4, EXIT_COL, 8, exit cell.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port move  input  3  explorer command, sampled every rising edge: 000 STOP, 001 FORWARD, 010 LEFT, 011 RIGHT, 100 U_TURN, 101-111 illegal.
REQ-006 The block SHALL have port pos_row  output  4  current row, and pos_col  output  4  current column.
REQ-007 The block SHALL have port heading  output  2  current heading: 0 N, 1 E, 2 S, 3 W.
REQ-008 The block SHALL have port step_cnt  output  8  cells advanced, and deadend_cnt  output  4  U_TURNs executed.
REQ-009 The block SHALL have ports exit_reached  output  1, oob_err  output  1, and illegal_cmd  output  1.

Function
REQ-010 Each output SHALL be registered, reflecting the move sampled at edge N immediately after edge N (latency 1 clock).
REQ-011 Heading updates SHALL use mod-4 arithmetic: LEFT heading-1, RIGHT heading+1, U_TURN heading+2, FORWARD and STOP unchanged.
REQ-012 FORWARD, LEFT, RIGHT and U_TURN SHALL first apply the new heading, then advance one cell along it in the same cycle.
REQ-013 Advancing SHALL change the position as follows: N col+1, S col-1, E row+1, W row-1.
REQ-014 STOP SHALL leave all state unchanged.
REQ-015 The FSM SHALL have four states, IDLE, TRACK, DONE and ERROR, and SHALL reset to IDLE.
REQ-016 In IDLE, STOP SHALL keep the FSM in IDLE; any legal non-STOP move SHALL be applied and the FSM SHALL enter TRACK.
REQ-017 In TRACK, each legal move SHALL be applied.
REQ-018 If the resulting position equals (EXIT_ROW, EXIT_COL), the FSM SHALL enter DONE and exit_reached SHALL be set (sticky).
REQ-019 If a move would yield row outside 0..ROWS-1 or col outside 0..COLS-1, the position SHALL be held, the heading SHALL still update, oob_err SHALL be set (sticky), the FSM SHALL enter ERROR, and step_cnt SHALL NOT increment.
REQ-020 DONE and ERROR SHALL be terminal: all moves are ignored and outputs are frozen until reset.
REQ-021 step_cnt SHALL increment by 1 per successful advance and SHALL saturate at 255.
REQ-022 deadend_cnt SHALL increment per U_TURN and SHALL saturate at 15; an out-of-bounds U_TURN SHALL still count.
REQ-023 Illegal codes SHALL be treated as STOP and SHALL pulse illegal_cmd high for exactly one cycle per illegal sample, in any state.
REQ-024 Column underflow from col 0 heading S SHALL be detected before 4-bit wrap; no wrapped position SHALL ever be output.

Reset
REQ-025 While rst_n is low, outputs SHALL asynchronously clear to: pos_row=START_ROW, pos_col=START_COL, heading=0 (N), step_cnt=0, deadend_cnt=0, all flags 0, FSM in IDLE.
REQ-026 Reset asserted mid-operation, including in DONE or ERROR, SHALL discard all history; the first rising edge after release SHALL sample move normally.

Configuration
REQ-027 With macro MOVE_TRACKER_VISIT_MAP_EN defined, the block SHALL hold a ROWS*COLS visited bitmap (start cell set at reset), SHALL add output revisit (1 bit, one-cycle pulse when an advance lands on an already-visited cell), and SHALL add output unique_cells (7 bits, count of set bits, reset value 1).
REQ-028 Without MOVE_TRACKER_VISIT_MAP_EN, the bitmap, revisit and unique_cells SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 After reset, move=001 x3: pos=(4,3), heading=0, step_cnt=3, FSM TRACK.
REQ-030 From (4,0) N, move=011, then 010: after the first edge pos=(5,0) heading=1; after the second, pos=(5,1) heading=0; step_cnt=2.
REQ-031 move=001 x8 from reset: pos=(4,8), exit_reached=1; subsequent 001 leaves pos, step_cnt=8 frozen.
REQ-032 From reset, 100: heading=2, col underflow, pos held (4,0), oob_err=1, deadend_cnt=1, step_cnt=0; later moves ignored.
REQ-033 Apply move=111 in TRACK: illegal_cmd high one cycle, state unchanged; assert rst_n low mid-cycle: outputs clear immediately without clock.
REQ-034 With MOVE_TRACKER_VISIT_MAP_EN: 001, 100 sequence: the second advance returns to (4,0) with revisit pulse=1 and unique_cells=2.
